// File: rtl/sample_capture_pkg.sv
// Shared types and helpers for the decimating sample-capture block.
package sample_capture_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } capture_state_t;

    function automatic int calc_period(input int clk_freq, input int sample_rate);
        return clk_freq / sample_rate;
    endfunction

endpackage

// File: rtl/sample_capture_if.sv
// Control, ADC and BRAM-write signals of sample_capture, grouped for port connection.
interface sample_capture_if #(
    parameter int ADDR_W = 8,
    parameter int ADC_W  = 16,
    parameter int DATA_W = 12
) ();
    import sample_capture_pkg::*;

    // adc_valid is a one-cycle strobe with no back-pressure: data is taken on every cycle
    // it is high, and wena likewise marks exactly one BRAM write per high cycle.
    logic                 trig;
    logic                 mode_cont;
    logic                 abort;
    logic [ADC_W-1:0]     adc_data;
    logic                 adc_valid;
    logic                 busy;
    logic                 done;
    logic [ADDR_W-1:0]    addr;
    logic                 wena;
    logic [DATA_W-1:0]    d_smpl;
    logic                 stale;
    capture_state_t       dbg_state;

    modport master (
        output trig, mode_cont, abort, adc_data, adc_valid,
        input  busy, done, addr, wena, d_smpl, stale, dbg_state
    );

    modport slave (
        input  trig, mode_cont, abort, adc_data, adc_valid,
        output busy, done, addr, wena, d_smpl, stale, dbg_state
    );

endinterface

// File: rtl/sample_capture_tick_gen.sv
// Free-running PERIOD counter with synchronous clear; o_tick marks the last count of each period.
module sample_tick_gen #(
    parameter int PERIOD = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);
    localparam int CTR_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [CTR_W-1:0] LAST = CTR_W'(PERIOD - 1);

    logic [CTR_W-1:0] r_ctr;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_ctr <= '0;
        end else if (i_en) begin
            r_ctr <= (r_ctr == LAST) ? '0 : r_ctr + CTR_W'(1);
        end
    end

    assign o_tick = i_en && (r_ctr == LAST);

endmodule

// File: rtl/sample_capture.sv
// Decimates the ADC stream to SAMPLE_RATE and writes DEPTH-sample frames into the FFT input BRAM.
module sample_capture
    import sample_capture_pkg::*;
#(
    parameter int CLK_FREQ    = 148500000,
    parameter int SAMPLE_RATE = 10000,
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 8,
    parameter int ADC_W       = 16,
    parameter int DATA_W      = 12
) (
    input  logic             clk,
    input  logic             rst,
    sample_capture_if.slave  bus
);
    localparam int PERIOD = calc_period(CLK_FREQ, SAMPLE_RATE);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    capture_state_t      r_state;
    capture_state_t      w_state_nxt;
    logic                r_busy;
    logic                r_done;
    logic                r_wena;
    logic                r_stale;
    logic                r_fresh;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_idx;
    logic [DATA_W-1:0]   r_d_smpl;
    logic [DATA_W-1:0]   r_latch;

    logic                w_tick;
    logic                w_tick_clr;
    logic                w_tick_en;
    logic                w_start;
    logic                w_write;
    logic                w_frame_end;
    logic [DATA_W-1:0]   w_adc_msb;
    logic [DATA_W-1:0]   w_sample;

    assign w_adc_msb  = bus.adc_data[ADC_W-1 -: DATA_W];
    assign w_tick_en  = (r_state == CAPTURE);
    assign w_tick_clr = (r_state == IDLE) || bus.abort;

    sample_tick_gen #(
        .PERIOD (PERIOD)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_tick_clr),
        .i_en   (w_tick_en),
        .o_tick (w_tick)
    );

    // A conversion arriving on the tick cycle bypasses the latch so the freshest value is stored.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_write     = 1'b0;
        w_frame_end = 1'b0;
        w_sample    = bus.adc_valid ? w_adc_msb : r_latch;
        unique case (r_state)
            IDLE: begin
                if (bus.trig && !bus.abort) begin
                    w_start     = 1'b1;
                    w_state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                if (bus.abort) begin
                    w_state_nxt = IDLE;
                end else if (w_tick) begin
                    w_write     = 1'b1;
                    w_frame_end = (r_idx == LAST_IDX);
                    if (w_frame_end && !bus.mode_cont) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Later assignments deliberately override earlier ones: start and write both consume freshness.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_wena   <= 1'b0;
            r_stale  <= 1'b0;
            r_fresh  <= 1'b0;
            r_addr   <= '0;
            r_idx    <= '0;
            r_d_smpl <= '0;
            r_latch  <= '0;
        end else begin
            r_wena <= w_write;
            r_done <= w_write && w_frame_end;
            r_busy <= (w_state_nxt == CAPTURE);
            if (bus.adc_valid) begin
                r_latch <= w_adc_msb;
                r_fresh <= 1'b1;
            end
            if (w_start) begin
                r_idx   <= '0;
                r_stale <= 1'b0;
                r_fresh <= 1'b0;
            end
            if (w_write) begin
                r_addr   <= r_idx;
                r_d_smpl <= w_sample;
                r_idx    <= r_idx + ADDR_W'(1);
                r_fresh  <= 1'b0;
                if (!bus.adc_valid && !r_fresh) begin
                    r_stale <= 1'b1;
                end
            end
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.wena      = r_wena;
    assign bus.addr      = r_addr;
    assign bus.d_smpl    = r_d_smpl;
    assign bus.stale     = r_stale;
    assign bus.dbg_state = r_state;

endmodule
